// File: rtl/menu_button_ctrl.sv
// menu_button_ctrl: hit-tests the cursor against the Start/Connect buttons,
// registers hover flags and emits single-cycle click strobes.
module menu_button_ctrl #(
  parameter int unsigned START_X0 = 220,
  parameter int unsigned START_X1 = 419,
  parameter int unsigned START_Y0 = 250,
  parameter int unsigned START_Y1 = 309,
  parameter int unsigned CONN_X0  = 220,
  parameter int unsigned CONN_X1  = 419,
  parameter int unsigned CONN_Y0  = 320,
  parameter int unsigned CONN_Y1  = 379
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       menu_active,
  input  logic [9:0] MOUSE_X,
  input  logic [9:0] MOUSE_Y,
  input  logic       MOUSE_LEFT,
  input  logic       connected,
  output logic       mouse_on_start_button,
  output logic       mouse_on_connect_button,
  output logic       start_pulse,
  output logic       connect_req,
  output logic [1:0] btn_state
);

  localparam int unsigned COORD_W = 10;

  localparam logic [COORD_W-1:0] SX0 = COORD_W'(START_X0);
  localparam logic [COORD_W-1:0] SX1 = COORD_W'(START_X1);
  localparam logic [COORD_W-1:0] SY0 = COORD_W'(START_Y0);
  localparam logic [COORD_W-1:0] SY1 = COORD_W'(START_Y1);
  localparam logic [COORD_W-1:0] CX0 = COORD_W'(CONN_X0);
  localparam logic [COORD_W-1:0] CX1 = COORD_W'(CONN_X1);
  localparam logic [COORD_W-1:0] CY0 = COORD_W'(CONN_Y0);
  localparam logic [COORD_W-1:0] CY1 = COORD_W'(CONN_Y1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARM_START = 2'd1,
    ARM_CONN  = 2'd2,
    WAIT_REL  = 2'd3
  } btn_state_t;

  btn_state_t state_q, state_d;
  logic       left_d;
  logic       hit_s, hit_c;
  logic       press, rel;
  logic       start_d, conn_d;

  // Rectangle hit tests (inclusive bounds) and mouse-button edge detection.
  always_comb begin
    hit_s = (MOUSE_X >= SX0) && (MOUSE_X <= SX1) && (MOUSE_Y >= SY0) && (MOUSE_Y <= SY1);
    hit_c = (MOUSE_X >= CX0) && (MOUSE_X <= CX1) && (MOUSE_Y >= CY0) && (MOUSE_Y <= CY1);
    press = MOUSE_LEFT & ~left_d;
    rel   = ~MOUSE_LEFT & left_d;
  end

  // Next-state and next-strobe logic; a disabled menu forces IDLE with no strobes.
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    conn_d  = 1'b0;
    if (!menu_active) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (press) begin
            if (hit_s)                  state_d = ARM_START;
            else if (hit_c && !connected) state_d = ARM_CONN;
            else                        state_d = WAIT_REL;
          end else if (MOUSE_LEFT && left_d) begin
            // held with no edge (e.g. through reset or re-enable): never arm
            state_d = WAIT_REL;
          end
        end
        ARM_START: begin
          if (rel) begin
            start_d = hit_s;
            state_d = IDLE;
          end
        end
        ARM_CONN: begin
          // link coming up while armed cancels the click, even on a same-cycle release
          if (connected) begin
            state_d = WAIT_REL;
          end else if (rel) begin
            conn_d  = hit_c;
            state_d = IDLE;
          end
        end
        WAIT_REL: begin
          if (!MOUSE_LEFT) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, button history and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q                 <= IDLE;
      left_d                  <= 1'b1;
      mouse_on_start_button   <= 1'b0;
      mouse_on_connect_button <= 1'b0;
      start_pulse             <= 1'b0;
      connect_req             <= 1'b0;
    end else begin
      state_q                 <= state_d;
      left_d                  <= MOUSE_LEFT;
      mouse_on_start_button   <= hit_s & menu_active;
      mouse_on_connect_button <= hit_c & menu_active;
      start_pulse             <= start_d;
      connect_req             <= conn_d;
    end
  end

  assign btn_state = state_q;

endmodule

// File: tb/tb_menu_button_ctrl.sv
// Directed bench for menu_button_ctrl: hover, click, cancel, gating, reset and disable.
module tb_menu_button_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       menu_active;
  logic [9:0] MOUSE_X;
  logic [9:0] MOUSE_Y;
  logic       MOUSE_LEFT;
  logic       connected;
  logic       mouse_on_start_button;
  logic       mouse_on_connect_button;
  logic       start_pulse;
  logic       connect_req;
  logic [1:0] btn_state;

  int pass_cnt = 0;
  int total_cnt = 0;

  menu_button_ctrl dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .menu_active             (menu_active),
    .MOUSE_X                 (MOUSE_X),
    .MOUSE_Y                 (MOUSE_Y),
    .MOUSE_LEFT              (MOUSE_LEFT),
    .connected               (connected),
    .mouse_on_start_button   (mouse_on_start_button),
    .mouse_on_connect_button (mouse_on_connect_button),
    .start_pulse             (start_pulse),
    .connect_req             (connect_req),
    .btn_state               (btn_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Checks every output against the expected hover/strobe/state values.
  task automatic chk_all(input string tag, input logic hs, input logic hc,
                         input logic sp, input logic cr, input logic [1:0] st);
    chk1({tag, ".hover_start"}, mouse_on_start_button, hs);
    chk1({tag, ".hover_conn"},  mouse_on_connect_button, hc);
    chk1({tag, ".start_pulse"}, start_pulse, sp);
    chk1({tag, ".connect_req"}, connect_req, cr);
    chk2({tag, ".btn_state"},   btn_state, st);
  endtask

  task automatic at(input int x, input int y);
    MOUSE_X = 10'(x);
    MOUSE_Y = 10'(y);
  endtask

  initial begin
    rst_n = 1'b0; menu_active = 1'b1; MOUSE_LEFT = 1'b0; connected = 1'b0;
    at(300, 280);
    tick(); tick();
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    rst_n = 1'b1;

    // hover
    tick();               chk_all("hov_start", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    at(300, 350); tick(); chk_all("hov_conn",  1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    at(419, 309); tick(); chk_all("hov_corner", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    at(420, 309); tick(); chk_all("hov_x_out", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    at(219, 250); tick(); chk_all("hov_x_lo",  1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    at(220, 379); tick(); chk_all("hov_c_edge", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    at(220, 380); tick(); chk_all("hov_c_out", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

    // start click: 5 cycles held
    at(300, 280); tick();
    MOUSE_LEFT = 1'b1; tick(); chk_all("sc_press", 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
    for (int i = 0; i < 4; i++) begin
      tick(); chk_all("sc_hold", 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
    end
    MOUSE_LEFT = 1'b0; tick(); chk_all("sc_rel", 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
    tick();                    chk_all("sc_after", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

    // cancelled: press on Start, drag off, release
    MOUSE_LEFT = 1'b1; tick(); chk2("cx1_press", btn_state, 2'd1);
    at(10, 10); tick();        chk_all("cx1_drag", 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
    MOUSE_LEFT = 1'b0; tick(); chk_all("cx1_rel", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    tick();                    chk1("cx1_after", start_pulse, 1'b0);

    // cancelled: press on empty space, drag onto Start, release
    MOUSE_LEFT = 1'b1; tick(); chk2("cx2_press", btn_state, 2'd3);
    at(300, 280); tick();      chk_all("cx2_drag", 1'b1, 1'b0, 1'b0, 1'b0, 2'd3);
    MOUSE_LEFT = 1'b0; tick(); chk_all("cx2_rel", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    tick();                    chk1("cx2_after", start_pulse, 1'b0);

    // connect press while connected: hover still reported, no request
    at(300, 350); connected = 1'b1;
    MOUSE_LEFT = 1'b1; tick(); chk_all("cg1_press", 1'b0, 1'b1, 1'b0, 1'b0, 2'd3);
    MOUSE_LEFT = 1'b0; tick(); chk_all("cg1_rel", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    tick();                    chk1("cg1_after", connect_req, 1'b0);
    connected = 1'b0;

    // connected rises while held
    MOUSE_LEFT = 1'b1; tick(); chk2("cg2_press", btn_state, 2'd2);
    connected = 1'b1; tick();  chk2("cg2_conn", btn_state, 2'd3);
    MOUSE_LEFT = 1'b0; tick(); chk_all("cg2_rel", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    tick();                    chk1("cg2_after", connect_req, 1'b0);
    connected = 1'b0;

    // connected rises in the same cycle as release
    MOUSE_LEFT = 1'b1; tick(); chk2("cg3_press", btn_state, 2'd2);
    connected = 1'b1; MOUSE_LEFT = 1'b0; tick();
    chk_all("cg3_rel", 1'b0, 1'b1, 1'b0, 1'b0, 2'd3);
    tick();                    chk_all("cg3_after", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    connected = 1'b0;

    // normal connect click
    MOUSE_LEFT = 1'b1; tick(); chk2("cc_press", btn_state, 2'd2);
    MOUSE_LEFT = 1'b0; tick(); chk_all("cc_rel", 1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
    tick();                    chk_all("cc_after", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);

    // back-to-back start clicks at minimum spacing
    at(300, 280);
    MOUSE_LEFT = 1'b1; tick(); chk2("bb_p1", btn_state, 2'd1);
    MOUSE_LEFT = 1'b0; tick(); chk1("bb_r1", start_pulse, 1'b1);
    MOUSE_LEFT = 1'b1; tick(); chk_all("bb_p2", 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
    MOUSE_LEFT = 1'b0; tick(); chk_all("bb_r2", 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
    tick();                    chk1("bb_after", start_pulse, 1'b0);

    // button held through reset on Start
    MOUSE_LEFT = 1'b1; rst_n = 1'b0; tick();
    chk_all("rh_reset", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    rst_n = 1'b1; tick();      chk_all("rh_held", 1'b1, 1'b0, 1'b0, 1'b0, 2'd3);
    MOUSE_LEFT = 1'b0; tick(); chk_all("rh_rel", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    tick();                    chk1("rh_after", start_pulse, 1'b0);

    // menu disabled while armed, release afterwards
    MOUSE_LEFT = 1'b1; tick(); chk2("md_press", btn_state, 2'd1);
    menu_active = 1'b0; tick(); chk_all("md_off", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    MOUSE_LEFT = 1'b0; tick(); chk_all("md_rel", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    menu_active = 1'b1; tick(); chk_all("md_on", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

    // release in the same cycle the menu is disabled
    MOUSE_LEFT = 1'b1; tick(); chk2("md2_press", btn_state, 2'd1);
    menu_active = 1'b0; MOUSE_LEFT = 1'b0; tick();
    chk_all("md2_rel", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    menu_active = 1'b1; tick(); chk_all("md2_after", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/menu_button_ctrl.md
# menu_button_ctrl

Upstream stage of the menu pixel generator. It hit-tests the mouse cursor against the Start and Connect button rectangles and produces the registered hover flags (`mouse_on_start_button`, `mouse_on_connect_button`) that the pixel generator uses for button colouring. It also runs a press/release state machine that emits single-cycle `start_pulse` and `connect_req` strobes to the top-level game FSM. A click counts only when the button is pressed and then released inside the same button.

## Interface
Parameters (all bounds inclusive, screen coordinates):
- `START_X0` 220 / `START_X1` 419: Start button left and right edges.
- `START_Y0` 250 / `START_Y1` 309: Start button top and bottom edges.
- `CONN_X0` 220 / `CONN_X1` 419: Connect button left and right edges.
- `CONN_Y0` 320 / `CONN_Y1` 379: Connect button top and bottom edges.

Ports:
- `clk` in 1: system clock. One clock domain only.
- `rst_n` in 1: synchronous, active-low reset.
- `menu_active` in 1: menu screen shown. Low means the block is disabled.
- `MOUSE_X` in 10: cursor x, range 0..639, synchronous to `clk`.
- `MOUSE_Y` in 10: cursor y, range 0..479, synchronous to `clk`.
- `MOUSE_LEFT` in 1: left button level, synchronous to `clk`.
- `connected` in 1: link established. Connect clicks are ignored while this is high.
- `mouse_on_start_button` out 1: registered hover flag for Start.
- `mouse_on_connect_button` out 1: registered hover flag for Connect.
- `start_pulse` out 1: one-cycle Start click strobe.
- `connect_req` out 1: one-cycle Connect click strobe.
- `btn_state` out 2: current FSM state, for debug.

## Operation
- Combinational hits:
  - `hit_s` = X0≤MOUSE_X≤X1 and Y0≤MOUSE_Y≤Y1, using the Start bounds.
  - `hit_c` is the same test using the Connect bounds.
  - The rectangles must not overlap; the parameters must keep them disjoint.
- Hover outputs:
  - `mouse_on_start_button` ← `hit_s & menu_active`, registered every cycle.
  - `mouse_on_connect_button` ← `hit_c & menu_active`, registered every cycle.
  - Hover is reported even when `connected`=1; the pixel generator gives `connected` priority.
- `left_d` register holds the previous `MOUSE_LEFT`.
  - `press` = `MOUSE_LEFT & ~left_d`.
  - `release` = `~MOUSE_LEFT & left_d`.
- FSM encoding: IDLE=0, ARM_START=1, ARM_CONN=2, WAIT_REL=3.
- IDLE transitions:
  - `press & hit_s` → ARM_START.
  - `press & hit_c & ~connected` → ARM_CONN.
  - Any other `press` → WAIT_REL. This covers a press on empty space, or on Connect while connected.
  - `MOUSE_LEFT & left_d` (button held with no edge) → WAIT_REL.
- ARM_START transitions:
  - Dragging off and back on while held is allowed; only the release position matters.
  - On `release`: if `hit_s`, assert `start_pulse` next cycle; → IDLE in either case.
- ARM_CONN transitions:
  - `connected` rising while armed → WAIT_REL, no pulse.
  - On `release & ~connected`: if `hit_c`, assert `connect_req` next cycle; → IDLE in either case.
- WAIT_REL transitions: `~MOUSE_LEFT` → IDLE.
- `menu_active`=0 overrides everything:
  - The FSM is forced to IDLE.
  - Pulses and hover flags are 0.
  - `left_d` keeps tracking `MOUSE_LEFT`.
- Simultaneous events:
  - A release in the same cycle that `menu_active` falls: no pulse.
  - A release in the same cycle that `connected` rises in ARM_CONN: no pulse; → WAIT_REL.
- Pulse behaviour:
  - Each pulse is high for exactly 1 cycle per click.
  - The two pulses are never high together.
  - There is no pulse without a preceding in-button press.

## Timing
- Reset (`rst_n`=0 at a `clk` edge):
  - State IDLE; all outputs 0; `btn_state`=0.
  - `left_d` is reset to 1, so a button held through reset cannot arm; the FSM goes to WAIT_REL until release.
- Hover latency: 1 cycle from the MOUSE_X/Y change to the flag update.
- Click latency: release sampled at edge N → pulse high during cycle N+1 → low at N+2. `btn_state` reads IDLE at N+1.
- Press latency: a press sampled at edge N gives `btn_state`=ARM_* at N+1.
- Back-to-back clicks: a new press is accepted in the cycle after the pulse (state IDLE). Minimum click-to-click spacing is 2 cycles of button low/high.

## Test plan
- Hover: cursor (300,280) → `mouse_on_start_button`=1 one cycle later. Cursor (300,350) → connect flag=1, start flag=0. Cursor (419,309) → start flag=1; (420,309) → both 0.
- Start click: at (300,280) press 5 cycles then release → exactly one `start_pulse` 1 cycle after release; `btn_state` sequence 0,1,0.
- Cancelled click: press at (300,280), drag to (10,10), release → no pulse, state IDLE. Press at (10,10), drag onto Start, release → no pulse via WAIT_REL.
- Connect gating:
  - Press on Connect with `connected`=1 → WAIT_REL, no `connect_req`.
  - With `connected`=0, press, raise `connected` while held, release → no pulse.
  - With `connected`=0 throughout, press then release on Connect → one `connect_req`.
- Reset/disable:
  - Hold `MOUSE_LEFT`=1 across `rst_n` low→high with cursor on Start, release → no pulse.
  - Drop `menu_active` during ARM_START, then release → no pulse; hover flags 0.
